// File: rtl/s38417_phase_writer.sv
// Three-phase bank writer: serialises a 3-bit word through one-hot phase selects and commits it atomically.
// Optional PHASE_MASK_EN adds req_mask[2:0] to skip phases (skipped bits keep the old bank value).
module s38417_phase_writer #(
  parameter int NBANK = 4,
  parameter int IDXW  = 2
) (
  input  logic                 CK,
  input  logic                 RSTn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDXW-1:0]      req_bank,
  input  logic [2:0]           req_data,
`ifdef PHASE_MASK_EN
  input  logic [2:0]           req_mask,
`endif
  input  logic                 abort,
  output logic [2:0]           sel_o,
  output logic                 wbit_o,
  output logic [3*NBANK-1:0]   bank_q,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  // Request handshake: a transfer happens on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE and req_* are ignored in every other state.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH0  = 3'd1,
    PH1  = 3'd2,
    PH2  = 3'd3,
    CMT  = 3'd4
  } state_t;

  localparam int unsigned NB = NBANK;

  state_t          state;
  logic [IDXW-1:0] idx_q;
  logic [2:0]      data_q;
  logic [2:0]      shadow;
  logic [2:0]      mask_q;
  logic [2:0]      req_mask_eff;
  logic [2:0]      bank_r [NBANK];
  logic            in_range;
  logic [1:0]      phase_from;
  state_t          accept_ns;
  state_t          phase_ns;

`ifdef PHASE_MASK_EN
  assign req_mask_eff = req_mask;
`else
  assign req_mask_eff = 3'b111;
  assign mask_q       = 3'b111;
`endif

  // First enabled phase at or after position 'from'; CMT when none remains.
  function automatic state_t next_phase(input logic [2:0] m, input logic [1:0] from);
    if (from == 2'd0 && m[0])      return PH0;
    else if (from <= 2'd1 && m[1]) return PH1;
    else if (from <= 2'd2 && m[2]) return PH2;
    else                           return CMT;
  endfunction

  function automatic logic [2:0] sel_of(input state_t s);
    case (s)
      PH0:     return 3'b001;
      PH1:     return 3'b010;
      PH2:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    phase_from = 2'd3;
    case (state)
      PH0:     phase_from = 2'd1;
      PH1:     phase_from = 2'd2;
      default: phase_from = 2'd3;
    endcase
  end

  assign accept_ns = next_phase(req_mask_eff, 2'd0);
  assign phase_ns  = next_phase(mask_q, phase_from);
  assign in_range  = (32'(idx_q) < NB);

  always_ff @(posedge CK) begin
    if (!RSTn) begin
      state  <= IDLE;
      idx_q  <= '0;
      data_q <= 3'b000;
      shadow <= 3'b000;
      sel_o  <= 3'b000;
      wbit_o <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef PHASE_MASK_EN
      mask_q <= 3'b000;
`endif
      for (int i = 0; i < NBANK; i++) bank_r[i] <= 3'b000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q  <= req_bank;
            data_q <= req_data;
            shadow <= 3'b000;
`ifdef PHASE_MASK_EN
            mask_q <= req_mask;
`endif
            state  <= accept_ns;
            sel_o  <= sel_of(accept_ns);
            wbit_o <= |(sel_of(accept_ns) & req_data);
          end
        end
        PH0, PH1, PH2: begin
          if (abort) begin
            state  <= IDLE;
            sel_o  <= 3'b000;
            wbit_o <= 1'b0;
          end else begin
            shadow <= (shadow & ~sel_of(state)) | (sel_of(state) & data_q);
            state  <= phase_ns;
            sel_o  <= sel_of(phase_ns);
            wbit_o <= |(sel_of(phase_ns) & data_q);
          end
        end
        CMT: begin
          // Merge keeps bits of skipped phases from the committed word.
          if (in_range)
            bank_r[idx_q] <= (shadow & mask_q) | (bank_r[idx_q] & ~mask_q);
          done   <= 1'b1;
          err    <= ~in_range;
          state  <= IDLE;
          sel_o  <= 3'b000;
          wbit_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          sel_o  <= 3'b000;
          wbit_o <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    assign bank_q[3*i +: 3] = bank_r[i];
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
